window_ctrl: RTL and testbench



---
 rtl/cartoon_pkg.sv | 37 +++
 rtl/win_addr_gen.sv | 27 ++
 rtl/window_ctrl.sv | 151 +++++++++++++++
 tb/tb_window_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cartoon_pkg.sv
// Shared types and constants for the cartoon-filter window scheduler.
// Slot numbering: slot = 3*(dr+1) + (dc+1), slot 0 is the top-left neighbour.
package cartoon_pkg;

    localparam int PIX_W   = 24;
    localparam int WIN_PIX = 9;
    localparam int WIN_W   = PIX_W * WIN_PIX;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        ISSUE = 3'd3,
        DONE  = 3'd4
    } win_state_t;

    typedef logic [PIX_W-1:0] rgb_t;

    // Row offset of a slot, biased by +1 so it stays unsigned (0,1,2 = -1,0,+1).
    function automatic logic [1:0] slot_dr(input logic [3:0] slot);
        case (slot)
            4'd0, 4'd1, 4'd2: return 2'd0;
            4'd3, 4'd4, 4'd5: return 2'd1;
            default:          return 2'd2;
        endcase
    endfunction

    // Column offset of a slot, biased by +1 in the same way.
    function automatic logic [1:0] slot_dc(input logic [3:0] slot);
        case (slot)
            4'd0, 4'd3, 4'd6: return 2'd0;
            4'd1, 4'd4, 4'd7: return 2'd1;
            default:          return 2'd2;
        endcase
    endfunction

endpackage

// File: rtl/win_addr_gen.sv
// Combinational neighbour address: (row+dr)*IMG_W + (col+dc) for the given slot.
// Centres are always interior, so the biased offsets never underflow.
module win_addr_gen
    import cartoon_pkg::*;
#(
    parameter int IMG_W  = 320,
    parameter int ADDR_W = 17
) (
    input  logic [ADDR_W-1:0] row_i,
    input  logic [ADDR_W-1:0] col_i,
    input  logic [3:0]        slot_i,
    output logic [ADDR_W-1:0] addr_o
);

    localparam logic [ADDR_W-1:0] W_A = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    logic [ADDR_W-1:0] r_abs;
    logic [ADDR_W-1:0] c_abs;

    always_comb begin
        r_abs  = row_i + ADDR_W'(slot_dr(slot_i)) - ONE;
        c_abs  = col_i + ADDR_W'(slot_dc(slot_i)) - ONE;
        addr_o = r_abs * W_A + c_abs;
    end

endmodule

// File: rtl/window_ctrl.sv
// 3x3 window scheduler: fetches each interior neighbourhood over a one-outstanding
// read handshake and issues it downstream. Optional macro: WINDOW_REUSE_EN.
module window_ctrl
    import cartoon_pkg::*;
#(
    parameter int IMG_W  = 320,
    parameter int IMG_H  = 240,
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic              out_ready,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [PIX_W-1:0]  mem_rdata,
    input  logic              mem_rvalid,
    output logic [WIN_W-1:0]  pixelData,
    output logic              intensity_enable,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(IMG_W - 2);
    localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(IMG_H - 2);
    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

    win_state_t        state_q, state_d;
    logic [ADDR_W-1:0] row_q, row_d;
    logic [ADDR_W-1:0] col_q, col_d;
    logic [3:0]        slot_q, slot_d;
    logic              reuse_q, reuse_d;
    rgb_t              win_q [WIN_PIX];
    rgb_t              win_d [WIN_PIX];
    logic [ADDR_W-1:0] slot_addr;

    win_addr_gen #(
        .IMG_W  (IMG_W),
        .ADDR_W (ADDR_W)
    ) u_addr (
        .row_i  (row_q),
        .col_i  (col_q),
        .slot_i (slot_q),
        .addr_o (slot_addr)
    );

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q <= IDLE;
            row_q   <= ONE;
            col_q   <= ONE;
            slot_q  <= '0;
            reuse_q <= 1'b0;
            win_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            slot_q  <= slot_d;
            reuse_q <= reuse_d;
            win_q   <= win_d;
        end
    end

    // The address is presented for the whole REQ/WAIT span so it stays stable.
    assign mem_addr = (state_q == REQ || state_q == WAIT) ? slot_addr : '0;

    always_comb begin
        state_d          = state_q;
        row_d            = row_q;
        col_d            = col_q;
        slot_d           = slot_q;
        reuse_d          = reuse_q;
        win_d            = win_q;
        mem_req          = 1'b0;
        intensity_enable = 1'b0;
        busy             = 1'b0;
        done             = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = REQ;
                    row_d   = ONE;
                    col_d   = ONE;
                    slot_d  = '0;
                    reuse_d = 1'b0;
                end
            end
            REQ: begin
                busy    = 1'b1;
                mem_req = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                busy    = 1'b1;
                mem_req = !mem_rvalid;
                if (mem_rvalid) begin
                    win_d[slot_q] = mem_rdata;
                    if (slot_q == 4'd8) begin
                        state_d = ISSUE;
                    end else begin
                        // Reused windows only fetch the right-hand column (2,5,8).
                        slot_d  = reuse_q ? slot_q + 4'd3 : slot_q + 4'd1;
                        state_d = REQ;
                    end
                end
            end
            ISSUE: begin
                busy = 1'b1;
                if (out_ready) begin
                    intensity_enable = 1'b1;
                    if (row_q == ROW_LAST && col_q == COL_LAST) begin
                        state_d = DONE;
                    end else if (col_q < COL_LAST) begin
                        state_d = REQ;
                        col_d   = col_q + ONE;
`ifdef WINDOW_REUSE_EN
                        for (int k = 0; k < 3; k++) begin
                            win_d[3*k]   = win_q[3*k+1];
                            win_d[3*k+1] = win_q[3*k+2];
                        end
                        slot_d  = 4'd2;
                        reuse_d = 1'b1;
`else
                        slot_d  = '0;
`endif
                    end else begin
                        state_d = REQ;
                        col_d   = ONE;
                        row_d   = row_q + ONE;
                        slot_d  = '0;
                        reuse_d = 1'b0;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pixelData = '0;
        for (int i = 0; i < WIN_PIX; i++) begin
            pixelData[WIN_W-1-i*PIX_W -: PIX_W] = win_q[i];
        end
    end

endmodule

// File: tb/tb_window_ctrl.sv
// Bench for window_ctrl: a 4x4 and a 3x3 instance share one randomized memory
// responder; issued windows are compared against a queue built from frame geometry.
module tb_window_ctrl;

    localparam int AW = 8;

    logic clk;
    logic n_rst;
    logic out_ready;
    logic sel;
    logic mem_rvalid;
    logic [23:0] mem_rdata;

    logic start_a, mem_req_a, rvalid_a, ie_a, busy_a, done_a;
    logic [AW-1:0] mem_addr_a;
    logic [215:0] pix_a;
    logic start_b, mem_req_b, rvalid_b, ie_b, busy_b, done_b;
    logic [AW-1:0] mem_addr_b;
    logic [215:0] pix_b;

    logic m_req, m_ie, m_busy, m_done;
    logic [AW-1:0] m_addr;
    logic [215:0] m_pix;

    int checks = 0;
    int errors = 0;
    int win_cnt = 0;
    int done_cnt = 0;
    int hs_cnt = 0;
    int base_win, base_done;
    int lat_min, lat_max;
    logic [23:0] salt;
    logic ready_rand;
    logic resp_busy;
    logic [215:0] exp_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    window_ctrl #(.IMG_W(4), .IMG_H(4), .ADDR_W(AW)) u_dut_a (
        .clk(clk), .n_rst(n_rst), .start(start_a), .out_ready(out_ready),
        .mem_req(mem_req_a), .mem_addr(mem_addr_a), .mem_rdata(mem_rdata),
        .mem_rvalid(rvalid_a), .pixelData(pix_a), .intensity_enable(ie_a),
        .busy(busy_a), .done(done_a)
    );

    window_ctrl #(.IMG_W(3), .IMG_H(3), .ADDR_W(AW)) u_dut_b (
        .clk(clk), .n_rst(n_rst), .start(start_b), .out_ready(out_ready),
        .mem_req(mem_req_b), .mem_addr(mem_addr_b), .mem_rdata(mem_rdata),
        .mem_rvalid(rvalid_b), .pixelData(pix_b), .intensity_enable(ie_b),
        .busy(busy_b), .done(done_b)
    );

    assign rvalid_a = mem_rvalid & ~sel;
    assign rvalid_b = mem_rvalid & sel;
    assign m_req    = sel ? mem_req_b  : mem_req_a;
    assign m_addr   = sel ? mem_addr_b : mem_addr_a;
    assign m_ie     = sel ? ie_b       : ie_a;
    assign m_busy   = sel ? busy_b     : busy_a;
    assign m_done   = sel ? done_b     : done_a;
    assign m_pix    = sel ? pix_b      : pix_a;

    task automatic check(input string tag, input logic [215:0] obs, input logic [215:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] mem_word(input int a);
        return 24'(a) ^ salt;
    endfunction

    // Reference: every interior centre in row-major order, slot s at offset (s/3-1, s%3-1).
    task automatic expect_frame(input int w, input int h);
        logic [215:0] win;
        for (int r = 1; r < h - 1; r++) begin
            for (int c = 1; c < w - 1; c++) begin
                for (int s = 0; s < 9; s++) begin
                    win[215-24*s -: 24] = mem_word((r + s / 3 - 1) * w + (c + s % 3 - 1));
                end
                exp_q.push_back(win);
            end
        end
    endtask

    // Memory: one request at a time, data returned lat_min..lat_max cycles after REQ.
    initial begin
        logic fire;
        logic [AW-1:0] req_addr;
        int cnt;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        resp_busy  = 1'b0;
        req_addr   = '0;
        cnt        = 0;
        forever begin
            @(negedge clk);
            fire = 1'b0;
            if (mem_rvalid) check("req_drop", m_req, 1'b0);
            if (!resp_busy && m_req) begin
                resp_busy = 1'b1;
                req_addr  = m_addr;
                cnt       = $urandom_range(lat_max, lat_min);
            end
            if (resp_busy) begin
                if (m_req) check("addr_stable", m_addr, req_addr);
                cnt--;
                if (cnt == 0) begin
                    fire      = 1'b1;
                    resp_busy = 1'b0;
                    hs_cnt++;
                end
            end
            @(posedge clk);
            #1;
            mem_rvalid = fire;
            mem_rdata  = fire ? mem_word(int'(req_addr)) : 24'h0;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ready_rand) out_ready = ($urandom_range(3, 0) != 0);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (n_rst) begin
                if (m_ie) begin
                    win_cnt++;
                    check("win_expected", 216'(exp_q.size() > 0), 216'(1));
                    if (exp_q.size() > 0) check("window", m_pix, exp_q.pop_front());
                end
                if (m_done) done_cnt++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic begin_frame(input int w, input int h, input logic s);
        sel       = s;
        hs_cnt    = 0;
        base_win  = win_cnt;
        base_done = done_cnt;
        expect_frame(w, h);
        if (s) start_b = 1'b1;
        else   start_a = 1'b1;
        step();
        start_a = 1'b0;
        start_b = 1'b0;
        @(negedge clk);
        check("busy_after_start", m_busy, 1'b1);
    endtask

    task automatic wait_done(input int budget);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (m_done) seen = 1'b1;
        end
        check("done_seen", seen, 1'b1);
    endtask

    task automatic finish_frame(input int w, input int h);
        int rows, cols, exp_hs;
        step();
        step();
        @(negedge clk);
        rows = h - 2;
        cols = w - 2;
`ifdef WINDOW_REUSE_EN
        exp_hs = rows * (9 + 3 * (cols - 1));
`else
        exp_hs = 9 * rows * cols;
`endif
        check("win_count", 216'(win_cnt - base_win), 216'(rows * cols));
        check("done_count", 216'(done_cnt - base_done), 216'(1));
        check("handshakes", 216'(hs_cnt), 216'(exp_hs));
        check("exp_q_empty", 216'(exp_q.size()), 216'(0));
        check("idle_busy", m_busy, 1'b0);
    endtask

    initial begin
        logic found;
        logic [215:0] snap;
        n_rst = 1'b0; start_a = 1'b0; start_b = 1'b0; sel = 1'b0;
        out_ready = 1'b1; ready_rand = 1'b0; salt = '0; lat_min = 1; lat_max = 1;
        repeat (3) step();
        @(negedge clk);
        check("rst_busy", busy_a, 1'b0);
        check("rst_req", mem_req_a, 1'b0);
        check("rst_addr", mem_addr_a, '0);
        check("rst_pix", pix_a, '0);
        check("rst_ie", ie_a, 1'b0);
        check("rst_done", done_a, 1'b0);
        check("rst_busy_b", busy_b, 1'b0);
        step();
        n_rst = 1'b1;
        step();

        // Data equals address, single-cycle latency, always ready.
        begin_frame(4, 4, 1'b0);
        wait_done(2000);
        finish_frame(4, 4);

        // Random latency, random data and random back-pressure.
        salt = 24'($urandom); lat_min = 1; lat_max = 7; ready_rand = 1'b1;
        begin_frame(4, 4, 1'b0);
        wait_done(5000);
        finish_frame(4, 4);
        salt = 24'($urandom);
        begin_frame(3, 3, 1'b1);
        wait_done(2000);
        finish_frame(3, 3);
        ready_rand = 1'b0;
        step();
        out_ready = 1'b1;

        // Hold the first window in ISSUE with out_ready low.
        salt = 24'($urandom); lat_min = 1; lat_max = 3; out_ready = 1'b0;
        begin_frame(4, 4, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 500 && !found; i++) begin
            @(negedge clk);
            if (m_busy && !m_req && !mem_rvalid) found = 1'b1;
        end
        check("issue_reached", found, 1'b1);
        snap = m_pix;
        for (int i = 0; i < 5; i++) begin
            check("stall_ie", m_ie, 1'b0);
            check("stall_pix", m_pix, snap);
            @(negedge clk);
        end
        step();
        out_ready = 1'b1;
        @(negedge clk);
        check("issue_on_ready", m_ie, 1'b1);
        check("issue_pix", m_pix, snap);
        wait_done(3000);
        finish_frame(4, 4);

        // Abort during the first fetch of window 2; the late read must be ignored.
        salt = 24'($urandom) | 24'h1; lat_min = 5; lat_max = 5;
        begin_frame(4, 4, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 500 && !found; i++) begin
            @(negedge clk);
            if (win_cnt != base_win) found = 1'b1;
        end
        check("win1_reached", found, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (m_req) found = 1'b1;
        end
        check("win2_req", found, 1'b1);
        @(negedge clk);
        step();
        n_rst = 1'b0;
        step();
        n_rst = 1'b1;
        @(negedge clk);
        check("abort_busy", m_busy, 1'b0);
        check("abort_req", m_req, 1'b0);
        check("abort_addr", m_addr, '0);
        check("abort_ie", m_ie, 1'b0);
        check("abort_done", m_done, 1'b0);
        check("abort_pix", m_pix, '0);
        exp_q.delete();
        for (int i = 0; i < 20 && (resp_busy || mem_rvalid); i++) @(negedge clk);
        repeat (2) @(negedge clk);
        check("late_busy", m_busy, 1'b0);
        check("late_pix", m_pix, '0);
        step();
        lat_min = 1; lat_max = 4;
        begin_frame(4, 4, 1'b0);
        wait_done(3000);
        finish_frame(4, 4);

        // Start while busy and start during done are both ignored.
        begin_frame(4, 4, 1'b0);
        repeat (10) step();
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            @(negedge clk);
            if (m_done) found = 1'b1;
        end
        check("done_seen_busy_start", found, 1'b1);
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        @(negedge clk);
        check("start_in_done", m_busy, 1'b0);
        finish_frame(4, 4);
        begin_frame(4, 4, 1'b0);
        wait_done(3000);
        finish_frame(4, 4);

        // Smallest frame: one window of addresses 0..8.
        salt = '0; lat_min = 1; lat_max = 1;
        begin_frame(3, 3, 1'b1);
        wait_done(500);
        finish_frame(3, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
